// File: rtl/sync_monitor.sv
// rtl/sync_monitor.sv - periodic sync pulse lock monitor with flywheel and error counting
module sync_monitor #(
    parameter int PERIOD     = 4,
    parameter int LOCK_COUNT = 3,
    parameter int LOSS_COUNT = 2,
    parameter int ERR_W      = 8,
    localparam int PW        = ($clog2(PERIOD) < 1) ? 1 : $clog2(PERIOD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync_in,
    output logic             locked,
    output logic [PW-1:0]    phase,
    output logic             frame_start,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    // good_cnt must reach LOCK_COUNT+1 (first pulse plus LOCK_COUNT good intervals)
    localparam int GW = $clog2(LOCK_COUNT + 2);
    localparam int CW = $clog2(LOSS_COUNT + 1);

    localparam logic [PW-1:0] LAST_PHASE = PW'(PERIOD - 1);
    localparam logic [GW-1:0] GOOD_DONE  = GW'(LOCK_COUNT + 1);
    localparam logic [CW-1:0] LOSS_LIM   = CW'(LOSS_COUNT);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [GW-1:0]     good_cnt, good_nx;
    logic [CW-1:0]     cons_err, cons_nx;
    logic [PW-1:0]     phase_nx;
    logic              locked_nx, frame_nx, errp_nx;
    logic [ERR_W-1:0]  count_nx;
    logic              slot;
    logic              err;

    // State and all registered outputs; reset clears everything immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            good_cnt    <= '0;
            cons_err    <= '0;
            phase       <= '0;
            locked      <= 1'b0;
            frame_start <= 1'b0;
            err_pulse   <= 1'b0;
            err_count   <= '0;
        end else begin
            state       <= state_nx;
            good_cnt    <= good_nx;
            cons_err    <= cons_nx;
            phase       <= phase_nx;
            locked      <= locked_nx;
            frame_start <= frame_nx;
            err_pulse   <= errp_nx;
            err_count   <= count_nx;
        end
    end

    // Next-state, phase tracking, flywheel strobes and error accounting
    always_comb begin
        state_nx = state;
        good_nx  = good_cnt;
        cons_nx  = cons_err;
        frame_nx = 1'b0;
        errp_nx  = 1'b0;
        count_nx = err_count;
        slot     = (phase == LAST_PHASE);
        err      = 1'b0;
        phase_nx = slot ? '0 : phase + 1'b1;

        case (state)
            HUNT: begin
                if (sync_in) begin
                    state_nx = VERIFY;
                    phase_nx = '0;
                    good_nx  = GW'(1);
                end
            end
            VERIFY: begin
                if (sync_in) begin
                    phase_nx = '0;
                    if (slot) begin
                        good_nx = good_cnt + 1'b1;
                        if (good_cnt + 1'b1 == GOOD_DONE) begin
                            state_nx = LOCKED;
                        end
                    end else begin
                        // early pulse: treat it as a fresh first pulse
                        good_nx = GW'(1);
                    end
                end else if (slot) begin
                    state_nx = HUNT;
                    good_nx  = '0;
                end
            end
            LOCKED: begin
                // phase keeps free-running here; pulses never resync it
                frame_nx = slot;
                err      = slot ? !sync_in : sync_in;
                if (err) begin
                    errp_nx = 1'b1;
                    if (err_count != {ERR_W{1'b1}}) begin
                        count_nx = err_count + 1'b1;
                    end
                    if (cons_err + 1'b1 == LOSS_LIM) begin
                        state_nx = HUNT;
                        cons_nx  = '0;
                        good_nx  = '0;
                    end else begin
                        cons_nx = cons_err + 1'b1;
                    end
                end else if (slot) begin
                    cons_nx = '0;
                end
            end
            default: begin
                state_nx = HUNT;
                good_nx  = '0;
                cons_nx  = '0;
            end
        endcase

        locked_nx = (state_nx == LOCKED);
    end

endmodule

// File: tb/tb_sync_monitor.sv
// tb/tb_sync_monitor.sv - scoreboard bench for sync_monitor
module tb_sync_monitor;

    localparam int PW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sync_in = 1'b0;
    logic          locked;
    logic [PW-1:0] phase;
    logic          frame_start;
    logic          err_pulse;
    logic [1:0]    err_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic prev_locked = 1'b0;

    // kind: 0 = frame_start, 1 = err_pulse (val = err_count), 2 = locked edge (val = new level)
    typedef struct {
        int cyc;
        int kind;
        int val;
    } ev_t;
    ev_t exp_q[$];

    sync_monitor #(
        .PERIOD(4),
        .LOCK_COUNT(3),
        .LOSS_COUNT(2),
        .ERR_W(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sync_in(sync_in),
        .locked(locked),
        .phase(phase),
        .frame_start(frame_start),
        .err_pulse(err_pulse),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int kind, input int val, input int c);
        ev_t e;
        e.cyc = c;
        e.kind = kind;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int kind, input int val);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event got kind=%0d val=%0d cyc=%0d, none expected", kind, val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val != val || e.cyc != cyc) begin
                bad++;
                $display("FAIL event got kind=%0d val=%0d cyc=%0d, want kind=%0d val=%0d cyc=%0d",
                         kind, val, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    // Monitor: every strobe or locked edge is matched against the scoreboard
    always @(negedge clk) begin
        if (frame_start === 1'b1) check_ev(0, 0);
        if (err_pulse === 1'b1) check_ev(1, int'(err_count));
        if (locked !== prev_locked) check_ev(2, int'(locked));
        prev_locked = locked;
    end

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic drv(input bit s);
        @(negedge clk);
        sync_in = s;
    endtask

    // One period: three quiet edges, then the expected-slot edge carrying p
    task automatic per(input bit p, input bit f, input bit e, input int c, input int l);
        drv(1'b0);
        drv(1'b0);
        drv(1'b0);
        drv(p);
        if (f) push(0, 0, cyc + 1);
        if (e) push(1, c, cyc + 1);
        if (l >= 0) push(2, l, cyc + 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_locked", int'(locked), 0);
        chk("reset_phase", int'(phase), 0);
        chk("reset_frame", int'(frame_start), 0);
        chk("reset_err_pulse", int'(err_pulse), 0);
        chk("reset_err_count", int'(err_count), 0);

        // first edge out of reset samples a pulse
        rst = 1'b0;
        sync_in = 1'b1;
        per(1, 0, 0, 0, -1);
        per(1, 0, 0, 0, -1);
        per(1, 0, 0, 0, 1);
        per(1, 1, 0, 0, -1);
        per(1, 1, 0, 0, -1);
        per(1, 1, 0, 0, -1);

        // single missing pulse: flywheel frame plus one error, lock held
        per(0, 1, 1, 1, -1);
        per(1, 1, 0, 0, -1);

        // two consecutive missing pulses drop lock; err_count survives
        per(0, 1, 1, 2, -1);
        per(0, 1, 1, 3, 0);
        per(1, 0, 0, 0, -1);
        per(1, 0, 0, 0, -1);
        per(1, 0, 0, 0, -1);
        per(1, 0, 0, 0, 1);
        per(1, 1, 0, 0, -1);

        // saturation at 3 with 2-bit counter
        per(0, 1, 1, 3, -1);
        per(1, 1, 0, 0, -1);

        // early pulse while locked, then a good slot
        drv(1'b0);
        drv(1'b1);
        push(1, 3, cyc + 1);
        drv(1'b0);
        drv(1'b1);
        push(0, 0, cyc + 1);

        // early pulse then missing slot: two consecutive errors, lock lost
        drv(1'b0);
        drv(1'b1);
        push(1, 3, cyc + 1);
        drv(1'b0);
        drv(1'b0);
        push(0, 0, cyc + 1);
        push(1, 3, cyc + 1);
        push(2, 0, cyc + 1);

        // VERIFY: missing slot back to HUNT, then early pulse restart
        per(1, 0, 0, 0, -1);
        per(0, 0, 0, 0, -1);
        per(1, 0, 0, 0, -1);
        per(1, 0, 0, 0, -1);
        drv(1'b0);
        drv(1'b1);
        per(1, 0, 0, 0, -1);
        per(1, 0, 0, 0, -1);
        per(1, 0, 0, 0, 1);
        per(1, 1, 0, 0, -1);

        // asynchronous reset mid-lock, between clock edges
        @(negedge clk);
        #2;
        rst = 1'b1;
        sync_in = 1'b1;
        push(2, 0, cyc + 1);
        #1;
        chk("async_rst_locked", int'(locked), 0);
        chk("async_rst_phase", int'(phase), 0);
        chk("async_rst_err_count", int'(err_count), 0);
        chk("async_rst_frame", int'(frame_start), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        per(1, 0, 0, 0, -1);
        per(1, 0, 0, 0, -1);
        per(1, 0, 0, 0, 1);
        per(1, 1, 0, 0, -1);
        per(0, 1, 1, 1, -1);
        drv(1'b0);
        drv(1'b0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sync_monitor.md
SYNC_MONITOR -- requirements
Module: sync_monitor

Interface
REQ-001 Parameter PERIOD, default 4, expected sync pulse spacing in clock cycles; legal range >= 2.
REQ-002 Parameter LOCK_COUNT, default 3, consecutive correctly spaced pulses needed to declare lock; legal range >= 1.
REQ-003 Parameter LOSS_COUNT, default 2, consecutive errors while locked that drop lock; legal range >= 1.
REQ-004 Parameter ERR_W, default 8, width of the error counter.
REQ-005 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 Port rst  input  1  asynchronous, active-high reset.
REQ-007 Port sync_in  input  1  one-cycle-high periodic sync pulse from the sync generator, same clock domain.
REQ-008 Port locked  output  1  high while in LOCKED state.
REQ-009 Port phase  output  PW=max(1,clog2(PERIOD))  position within period; 0 in the cycle after an accepted pulse.
REQ-010 Port frame_start  output  1  one-cycle strobe at each expected pulse position while locked.
REQ-011 Port err_pulse  output  1  one-cycle strobe for each detected error while locked.
REQ-012 Port err_count  output  ERR_W  saturating count of errors detected while locked.

Function
REQ-013 sync_in SHALL be sampled on each rising clk edge; "expected slot" = edge where phase == PERIOD-1.
REQ-014 States SHALL be HUNT, VERIFY, LOCKED; all outputs registered.
REQ-015 Phase rule: accepted pulse -> phase <= 0; otherwise phase <= phase+1, wrapping PERIOD-1 -> 0.
REQ-016 HUNT: sync_in=1 -> VERIFY, phase<=0, good_cnt<=1; sync_in=0 -> stay, phase free-runs.
REQ-017 VERIFY, pulse in expected slot: good_cnt+1; if result == LOCK_COUNT+1 -> LOCKED (LOCK_COUNT good intervals after first pulse), else stay; phase<=0.
REQ-018 VERIFY, pulse at any other phase (early): restart, stay VERIFY, phase<=0, good_cnt<=1.
REQ-019 VERIFY, no pulse in expected slot (missing): -> HUNT, good_cnt<=0.
REQ-020 LOCKED: frame_start SHALL assert in the cycle after every expected-slot edge, pulse present or not (flywheel); phase never resyncs while locked.
REQ-021 LOCKED, pulse in expected slot: consecutive-error counter cleared, no error.
REQ-022 LOCKED, missing pulse in expected slot, or pulse at any other phase: err_pulse strobe next cycle, err_count+1 (saturate at all-ones), consecutive-error counter +1; each early-pulse cycle is a separate error.
REQ-023 LOCKED, consecutive errors reach LOSS_COUNT: -> HUNT next cycle, locked<=0; triggering pulse (if any) not reused as first HUNT pulse.
REQ-024 err_count SHALL only change while LOCKED or on reset; it is not cleared on lock loss.
REQ-025 Only one state transition per cycle; HUNT-entry from LOCKED and an error strobe on the same edge SHALL both take effect.

Reset
REQ-026 rst=1 SHALL immediately force: state HUNT, locked=0, phase=0, frame_start=0, err_pulse=0, err_count=0, good_cnt=0, consecutive errors=0.
REQ-027 sync_in SHALL be ignored while rst=1; first edge with rst=0 samples normally (a held-high sync_in at that edge counts as a pulse).
REQ-028 Reset asserted mid-lock SHALL drop locked asynchronously, without waiting for clk.

Verification
REQ-029 Defaults, pulse every 4 cycles from reset release -> locked rises 1 cycle after 4th pulse edge; frame_start every 4th cycle thereafter; err_count=0.
REQ-030 Locked, one pulse omitted -> frame_start still asserts at that slot, err_pulse once, err_count=1, locked stays 1.
REQ-031 Locked, two consecutive pulses omitted -> err_count=2, locked=0 after 2nd missing slot, relocks after 4 further good pulses.
REQ-032 VERIFY, pulse arrives 2 cycles early -> phase restarts at 0, good_cnt=1, lock delayed by full LOCK_COUNT periods.
REQ-033 ERR_W=2, repeated single errors separated by good pulses -> err_count sticks at 3, locked stays 1.
REQ-034 Assert rst mid-lock between edges -> locked, phase, err_count read 0 before next clk edge; relock sequence as REQ-029.
